// File: rtl/alu_result_writeback.sv
// rtl/alu_result_writeback.sv - execute write-back stage: result select, size extension, one-entry output register
//
// Ports:
//   clk, rstN                      clock (rising edge), asynchronous active-low reset
//   inValid / inReady              upstream retire handshake
//   aluResult, memData, pc         ALU output (low two bits are the load byte offset), load word, PC
//   rtAddr, rdAddr                 candidate destination fields
//   regDst, resultSrc              destination select, result source select
//   loadSize, loadSigned           load width and extension mode
//   regWrite                       instruction writes a register
//   wbValid / wbReady              held entry handshake towards the register file
//   wbWrite, wbAddr, wbData        register file write port
//   alignErr                       held entry is a misaligned load
//   retireCount                    entries drained since reset
module alu_result_writeback #(
   parameter int DATA_W     = 32,
   parameter int REG_ADDR_W = 5,
   parameter int LINK_REG   = 31
) (
   input  logic                  clk,
   input  logic                  rstN,
   input  logic                  inValid,
   output logic                  inReady,
   input  logic [DATA_W-1:0]     aluResult,
   input  logic [DATA_W-1:0]     memData,
   input  logic [DATA_W-1:0]     pc,
   input  logic [REG_ADDR_W-1:0] rtAddr,
   input  logic [REG_ADDR_W-1:0] rdAddr,
   input  logic [1:0]            regDst,
   input  logic [1:0]            resultSrc,
   input  logic [1:0]            loadSize,
   input  logic                  loadSigned,
   input  logic                  regWrite,
   output logic                  wbValid,
   input  logic                  wbReady,
   output logic                  wbWrite,
   output logic [REG_ADDR_W-1:0] wbAddr,
   output logic [DATA_W-1:0]     wbData,
   output logic                  alignErr,
   output logic [31:0]           retireCount
);

   localparam logic [1:0] SRC_ALU  = 2'd0;
   localparam logic [1:0] SRC_LOAD = 2'd1;
   localparam logic [1:0] SRC_LINK = 2'd2;

   localparam logic [1:0] SIZE_HALF = 2'd1;
   localparam logic [1:0] SIZE_BYTE = 2'd2;

   logic                  valid_q;
   logic                  write_q;
   logic [REG_ADDR_W-1:0] addr_q;
   logic [DATA_W-1:0]     data_q;
   logic                  align_q;
   logic [31:0]           count_q;

   logic accept;
   logic drain;

   logic [1:0]            offset;
   logic [15:0]           half_sel;
   logic [7:0]            byte_sel;
   logic [DATA_W-1:0]     load_val;
   logic                  misalign;
   logic [DATA_W-1:0]     sel_data;
   logic [REG_ADDR_W-1:0] sel_addr;
   logic                  sel_write;

   assign inReady = !valid_q || wbReady;
   assign accept  = inValid && inReady;
   assign drain   = valid_q && wbReady;

   always_comb begin
      offset   = aluResult[1:0];
      half_sel = offset[1] ? memData[31:16] : memData[15:0];
      byte_sel = memData[7:0];
      case (offset)
         2'd0:    byte_sel = memData[7:0];
         2'd1:    byte_sel = memData[15:8];
         2'd2:    byte_sel = memData[23:16];
         default: byte_sel = memData[31:24];
      endcase

      // Reserved size 3 behaves as a word load, including its alignment rule.
      misalign = 1'b0;
      load_val = memData;
      if (loadSize == SIZE_HALF) begin
         misalign = offset[0];
         load_val = loadSigned ? {{(DATA_W-16){half_sel[15]}}, half_sel}
                               : {{(DATA_W-16){1'b0}}, half_sel};
      end else if (loadSize == SIZE_BYTE) begin
         load_val = loadSigned ? {{(DATA_W-8){byte_sel[7]}}, byte_sel}
                               : {{(DATA_W-8){1'b0}}, byte_sel};
      end else begin
         misalign = (offset != 2'd0);
      end
      // Only a load can be misaligned; other sources ignore the offset bits.
      if (resultSrc != SRC_LOAD) begin
         misalign = 1'b0;
      end

      case (resultSrc)
         SRC_ALU:  sel_data = aluResult;
         SRC_LOAD: sel_data = misalign ? '0 : load_val;
         SRC_LINK: sel_data = pc + DATA_W'(4);
         default:  sel_data = '0;
      endcase

      case (regDst)
         2'd0:    sel_addr = rtAddr;
         2'd1:    sel_addr = rdAddr;
         2'd2:    sel_addr = REG_ADDR_W'(LINK_REG);
         default: sel_addr = '0;
      endcase

      sel_write = regWrite && (regDst != 2'd3) && (sel_addr != '0) && !misalign;
   end

   always_ff @(posedge clk or negedge rstN) begin
      if (!rstN) begin
         valid_q <= 1'b0;
         write_q <= 1'b0;
         addr_q  <= '0;
         data_q  <= '0;
         align_q <= 1'b0;
         count_q <= '0;
      end else begin
         if (accept) begin
            valid_q <= 1'b1;
            write_q <= sel_write;
            addr_q  <= sel_addr;
            data_q  <= sel_data;
            align_q <= misalign;
         end else if (drain) begin
            // Clear the port so a stale entry never looks like a pending write.
            valid_q <= 1'b0;
            write_q <= 1'b0;
            addr_q  <= '0;
            data_q  <= '0;
            align_q <= 1'b0;
         end
         if (drain) begin
            count_q <= count_q + 32'd1;
         end
      end
   end

   assign wbValid     = valid_q;
   assign wbWrite     = write_q;
   assign wbAddr      = addr_q;
   assign wbData      = data_q;
   assign alignErr    = align_q;
   assign retireCount = count_q;

endmodule

// File: tb/tb_alu_result_writeback.sv
// tb/tb_alu_result_writeback.sv - directed self-checking bench for alu_result_writeback
module tb_alu_result_writeback;

   logic        clk;
   logic        rstN;
   logic        inValid;
   logic        inReady;
   logic [31:0] aluResult;
   logic [31:0] memData;
   logic [31:0] pc;
   logic [4:0]  rtAddr;
   logic [4:0]  rdAddr;
   logic [1:0]  regDst;
   logic [1:0]  resultSrc;
   logic [1:0]  loadSize;
   logic        loadSigned;
   logic        regWrite;
   logic        wbValid;
   logic        wbReady;
   logic        wbWrite;
   logic [4:0]  wbAddr;
   logic [31:0] wbData;
   logic        alignErr;
   logic [31:0] retireCount;

   int errors = 0;
   int checks = 0;
   logic [31:0] exp_cnt = 0;

   alu_result_writeback dut (
      .clk(clk), .rstN(rstN), .inValid(inValid), .inReady(inReady),
      .aluResult(aluResult), .memData(memData), .pc(pc),
      .rtAddr(rtAddr), .rdAddr(rdAddr), .regDst(regDst), .resultSrc(resultSrc),
      .loadSize(loadSize), .loadSigned(loadSigned), .regWrite(regWrite),
      .wbValid(wbValid), .wbReady(wbReady), .wbWrite(wbWrite), .wbAddr(wbAddr),
      .wbData(wbData), .alignErr(alignErr), .retireCount(retireCount)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic set_in(input logic [31:0] alu, input logic [31:0] mem, input logic [31:0] p,
                         input logic [4:0] rt, input logic [4:0] rd, input logic [1:0] dst,
                         input logic [1:0] src, input logic [1:0] sz, input logic sgn,
                         input logic rw);
      aluResult = alu; memData = mem; pc = p; rtAddr = rt; rdAddr = rd;
      regDst = dst; resultSrc = src; loadSize = sz; loadSigned = sgn; regWrite = rw;
   endtask

   // Present one instruction for one edge with wbReady=1; the entry is held after return.
   task automatic issue();
      inValid = 1'b1;
      @(posedge clk); #1;
      inValid = 1'b0;
   endtask

   task automatic drain_one();
      @(posedge clk); #1;
      exp_cnt = exp_cnt + 1;
   endtask

   task automatic test_reset();
      rstN = 1'b0; inValid = 1'b0; wbReady = 1'b1;
      set_in(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      repeat (2) @(posedge clk);
      #1;
      checks++; if (wbValid !== 1'b0) begin errors++; $display("FAIL reset_wbValid got=%0b exp=0", wbValid); end
      checks++; if (inReady !== 1'b1) begin errors++; $display("FAIL reset_inReady got=%0b exp=1", inReady); end
      checks++; if ({wbWrite, alignErr, wbAddr, wbData} !== 39'd0) begin errors++; $display("FAIL reset_wb_outputs got=%0b/%0b/%0d/%h exp=0", wbWrite, alignErr, wbAddr, wbData); end
      checks++; if (retireCount !== 32'd0) begin errors++; $display("FAIL reset_retireCount got=%0d exp=0", retireCount); end
      rstN = 1'b1;
      @(posedge clk); #1;
      exp_cnt = 0;
   endtask

   task automatic test_alu();
      set_in(32'h1234, 32'h0, 32'h0, 5'd9, 5'd5, 2'd1, 2'd0, 2'd0, 1'b0, 1'b1);
      issue();
      checks++; if (wbValid !== 1'b1) begin errors++; $display("FAIL alu_wbValid got=%0b exp=1", wbValid); end
      checks++; if (wbWrite !== 1'b1) begin errors++; $display("FAIL alu_wbWrite got=%0b exp=1", wbWrite); end
      checks++; if (wbAddr !== 5'd5) begin errors++; $display("FAIL alu_wbAddr got=%0d exp=5", wbAddr); end
      checks++; if (wbData !== 32'h1234) begin errors++; $display("FAIL alu_wbData got=%h exp=00001234", wbData); end
      drain_one();
      checks++; if (wbValid !== 1'b0) begin errors++; $display("FAIL alu_drained_wbValid got=%0b exp=0", wbValid); end
      checks++; if (retireCount !== 32'd1) begin errors++; $display("FAIL alu_retireCount got=%0d exp=1", retireCount); end
   endtask

   task automatic test_load_ext();
      logic [31:0] alu_v [6] = '{32'h3, 32'h0, 32'h2, 32'h2, 32'h2, 32'h8};
      logic [1:0]  sz_v  [6] = '{2'd2, 2'd2, 2'd1, 2'd1, 2'd2, 2'd0};
      logic        sg_v  [6] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
      logic [31:0] exp_v [6] = '{32'hFFFFFF80, 32'h00000001, 32'h000080FF, 32'hFFFF80FF,
                                 32'h000000FF, 32'h80FF7F01};
      for (int i = 0; i < 6; i++) begin
         set_in(alu_v[i], 32'h80FF7F01, 32'h0, 5'd7, 5'd3, 2'd0, 2'd1, sz_v[i], sg_v[i], 1'b1);
         issue();
         checks++; if (wbData !== exp_v[i]) begin errors++; $display("FAIL load_%0d_wbData got=%h exp=%h", i, wbData, exp_v[i]); end
         checks++; if ({wbWrite, alignErr, wbAddr} !== {1'b1, 1'b0, 5'd7}) begin errors++; $display("FAIL load_%0d_ctrl got=%0b/%0b/%0d exp=1/0/7", i, wbWrite, alignErr, wbAddr); end
         drain_one();
      end
      checks++; if (retireCount !== exp_cnt) begin errors++; $display("FAIL load_retireCount got=%0d exp=%0d", retireCount, exp_cnt); end
   endtask

   task automatic test_misalign();
      logic [31:0] alu_v [2] = '{32'h1001, 32'h2002};
      logic [1:0]  sz_v  [2] = '{2'd1, 2'd0};
      for (int i = 0; i < 2; i++) begin
         set_in(alu_v[i], 32'h80FF7F01, 32'h0, 5'd7, 5'd3, 2'd0, 2'd1, sz_v[i], 1'b1, 1'b1);
         issue();
         checks++; if (alignErr !== 1'b1) begin errors++; $display("FAIL misalign_%0d_alignErr got=%0b exp=1", i, alignErr); end
         checks++; if (wbWrite !== 1'b0) begin errors++; $display("FAIL misalign_%0d_wbWrite got=%0b exp=0", i, wbWrite); end
         checks++; if (wbData !== 32'h0) begin errors++; $display("FAIL misalign_%0d_wbData got=%h exp=0", i, wbData); end
         drain_one();
         checks++; if (retireCount !== exp_cnt) begin errors++; $display("FAIL misalign_%0d_retireCount got=%0d exp=%0d", i, retireCount, exp_cnt); end
      end
   endtask

   task automatic test_link();
      set_in(32'h1, 32'h0, 32'h00400010, 5'd7, 5'd3, 2'd2, 2'd2, 2'd0, 1'b0, 1'b1);
      issue();
      checks++; if (wbAddr !== 5'd31) begin errors++; $display("FAIL link_wbAddr got=%0d exp=31", wbAddr); end
      checks++; if (wbData !== 32'h00400014) begin errors++; $display("FAIL link_wbData got=%h exp=00400014", wbData); end
      checks++; if (wbWrite !== 1'b1) begin errors++; $display("FAIL link_wbWrite got=%0b exp=1", wbWrite); end
      drain_one();
      set_in(32'h1, 32'h0, 32'hFFFFFFFC, 5'd7, 5'd3, 2'd2, 2'd2, 2'd0, 1'b0, 1'b1);
      issue();
      checks++; if (wbData !== 32'h0) begin errors++; $display("FAIL link_wrap_wbData got=%h exp=0", wbData); end
      drain_one();
      set_in(32'hDEADBEEF, 32'h0, 32'h0, 5'd7, 5'd3, 2'd1, 2'd3, 2'd0, 1'b0, 1'b1);
      issue();
      checks++; if ({wbData, wbAddr, wbWrite} !== {32'h0, 5'd3, 1'b1}) begin errors++; $display("FAIL zero_src got=%h/%0d/%0b exp=0/3/1", wbData, wbAddr, wbWrite); end
      drain_one();
   endtask

   task automatic test_back_to_back();
      wbReady = 1'b0;
      set_in(32'hA, 32'h0, 32'h0, 5'd1, 5'd10, 2'd1, 2'd0, 2'd0, 1'b0, 1'b1);
      inValid = 1'b1;
      @(posedge clk); #1;
      set_in(32'hB, 32'h0, 32'h0, 5'd1, 5'd11, 2'd1, 2'd0, 2'd0, 1'b0, 1'b1);
      for (int i = 0; i < 3; i++) begin
         checks++; if (inReady !== 1'b0) begin errors++; $display("FAIL stall_%0d_inReady got=%0b exp=0", i, inReady); end
         checks++; if ({wbValid, wbWrite, wbAddr, wbData, alignErr} !== {1'b1, 1'b1, 5'd10, 32'hA, 1'b0}) begin errors++; $display("FAIL stall_%0d_hold got=%0b/%0b/%0d/%h/%0b exp=1/1/10/0000000a/0", i, wbValid, wbWrite, wbAddr, wbData, alignErr); end
         @(posedge clk); #1;
      end
      checks++; if (retireCount !== exp_cnt) begin errors++; $display("FAIL stall_retireCount got=%0d exp=%0d", retireCount, exp_cnt); end
      wbReady = 1'b1;
      #1;
      checks++; if (inReady !== 1'b1) begin errors++; $display("FAIL b2b_inReady got=%0b exp=1", inReady); end
      @(posedge clk); #1;
      exp_cnt = exp_cnt + 1;
      checks++; if ({wbValid, wbAddr, wbData} !== {1'b1, 5'd11, 32'hB}) begin errors++; $display("FAIL b2b_second got=%0b/%0d/%h exp=1/11/0000000b", wbValid, wbAddr, wbData); end
      set_in(32'hC, 32'h0, 32'h0, 5'd1, 5'd12, 2'd1, 2'd0, 2'd0, 1'b0, 1'b1);
      @(posedge clk); #1;
      exp_cnt = exp_cnt + 1;
      inValid = 1'b0;
      checks++; if ({wbValid, wbAddr, wbData} !== {1'b1, 5'd12, 32'hC}) begin errors++; $display("FAIL b2b_third got=%0b/%0d/%h exp=1/12/0000000c", wbValid, wbAddr, wbData); end
      checks++; if (retireCount !== exp_cnt) begin errors++; $display("FAIL b2b_mid_retireCount got=%0d exp=%0d", retireCount, exp_cnt); end
      drain_one();
      checks++; if (wbValid !== 1'b0) begin errors++; $display("FAIL b2b_empty_wbValid got=%0b exp=0", wbValid); end
      checks++; if (retireCount !== exp_cnt) begin errors++; $display("FAIL b2b_retireCount got=%0d exp=%0d", retireCount, exp_cnt); end
   endtask

   task automatic test_r0_and_reset();
      set_in(32'h55, 32'h0, 32'h0, 5'd7, 5'd0, 2'd1, 2'd0, 2'd0, 1'b0, 1'b1);
      issue();
      checks++; if ({wbValid, wbWrite, wbAddr} !== {1'b1, 1'b0, 5'd0}) begin errors++; $display("FAIL r0_write got=%0b/%0b/%0d exp=1/0/0", wbValid, wbWrite, wbAddr); end
      drain_one();
      set_in(32'h55, 32'h0, 32'h0, 5'd7, 5'd9, 2'd3, 2'd0, 2'd0, 1'b0, 1'b1);
      issue();
      checks++; if ({wbValid, wbWrite, wbAddr} !== {1'b1, 1'b0, 5'd0}) begin errors++; $display("FAIL nodest_write got=%0b/%0b/%0d exp=1/0/0", wbValid, wbWrite, wbAddr); end
      drain_one();
      checks++; if (retireCount !== exp_cnt) begin errors++; $display("FAIL nodest_retireCount got=%0d exp=%0d", retireCount, exp_cnt); end
      wbReady = 1'b0;
      set_in(32'h77, 32'h0, 32'h0, 5'd7, 5'd4, 2'd1, 2'd0, 2'd0, 1'b0, 1'b1);
      issue();
      checks++; if (wbValid !== 1'b1) begin errors++; $display("FAIL held_wbValid got=%0b exp=1", wbValid); end
      #2;
      rstN = 1'b0;
      #1;
      checks++; if ({wbValid, wbWrite, inReady} !== 3'b001) begin errors++; $display("FAIL async_reset_flags got=%0b/%0b/%0b exp=0/0/1", wbValid, wbWrite, inReady); end
      checks++; if (retireCount !== 32'd0) begin errors++; $display("FAIL async_reset_retireCount got=%0d exp=0", retireCount); end
      @(posedge clk); #1;
      rstN = 1'b1;
      wbReady = 1'b1;
      @(posedge clk); #1;
      checks++; if ({wbValid, retireCount} !== 33'd0) begin errors++; $display("FAIL post_reset got=%0b/%0d exp=0/0", wbValid, retireCount); end
   endtask

   initial begin
      test_reset();
      test_alu();
      test_load_ext();
      test_misalign();
      test_link();
      test_back_to_back();
      test_r0_and_reset();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
